adap_quan_inv: RTL and testbench

ADAP_QUAN_INV -- requirements
Module: adap_quan_inv

---
 rtl/adap_quan_inv.sv | 165 ++++++++++++++++
 tb/tb_adap_quan_inv.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/adap_quan_inv.sv
// G.726 inverse adaptive quantizer: codeword + scale factor -> sign-magnitude DQ.
// Three-stage RECONST / ADDA / ANTILOG pipeline with a global advance enable.
module adap_quan_inv (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [4:0]  I,
    input  logic [12:0] Y,
    input  logic [1:0]  RATE,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] DQ
);

    logic        s1_v_q, s1_v_d;
    logic        s1_dqs_q, s1_dqs_d;
    logic [11:0] s1_dqln_q, s1_dqln_d;
    logic [10:0] s1_y_q, s1_y_d;
    logic        s2_v_q, s2_v_d;
    logic        s2_dqs_q, s2_dqs_d;
    logic [11:0] s2_dql_q, s2_dql_d;
    logic        out_v_q, out_v_d;
    logic [15:0] dq_q, dq_d;

    logic        en;
    logic        sgn;
    logic [3:0]  idx;
    logic [11:0] dqln;
    logic [3:0]  dex;
    logic [14:0] mag;

    assign en        = !out_v_q || OUT_READY;
    assign IN_READY  = en;
    assign OUT_VALID = out_v_q;
    assign DQ        = dq_q;

    always_comb begin
        sgn = 1'b0;
        idx = 4'd0;
        unique case (RATE)
            2'b00: begin
                sgn = I[1];
                idx = {3'b0, I[1] ? ~I[0] : I[0]};
            end
            2'b01: begin
                sgn = I[2];
                idx = {2'b0, I[2] ? ~I[1:0] : I[1:0]};
            end
            2'b10: begin
                sgn = I[3];
                idx = {1'b0, I[3] ? ~I[2:0] : I[2:0]};
            end
            default: begin
                sgn = I[4];
                idx = I[4] ? ~I[3:0] : I[3:0];
            end
        endcase
    end

    // 12'h800 is the log-domain minus infinity; 12'hFBE is -66
    always_comb begin
        dqln = 12'h800;
        unique case (RATE)
            2'b00: dqln = idx[0] ? 12'd365 : 12'd116;
            2'b01: begin
                unique case (idx[1:0])
                    2'd0:    dqln = 12'h800;
                    2'd1:    dqln = 12'd135;
                    2'd2:    dqln = 12'd273;
                    default: dqln = 12'd373;
                endcase
            end
            2'b10: begin
                unique case (idx[2:0])
                    3'd0:    dqln = 12'h800;
                    3'd1:    dqln = 12'd4;
                    3'd2:    dqln = 12'd135;
                    3'd3:    dqln = 12'd213;
                    3'd4:    dqln = 12'd273;
                    3'd5:    dqln = 12'd323;
                    3'd6:    dqln = 12'd373;
                    default: dqln = 12'd425;
                endcase
            end
            default: begin
                unique case (idx)
                    4'd0:    dqln = 12'h800;
                    4'd1:    dqln = 12'hFBE;
                    4'd2:    dqln = 12'd28;
                    4'd3:    dqln = 12'd104;
                    4'd4:    dqln = 12'd169;
                    4'd5:    dqln = 12'd224;
                    4'd6:    dqln = 12'd274;
                    4'd7:    dqln = 12'd318;
                    4'd8:    dqln = 12'd358;
                    4'd9:    dqln = 12'd395;
                    4'd10:   dqln = 12'd429;
                    4'd11:   dqln = 12'd459;
                    4'd12:   dqln = 12'd488;
                    4'd13:   dqln = 12'd514;
                    4'd14:   dqln = 12'd539;
                    default: dqln = 12'd566;
                endcase
            end
        endcase
    end

    // Shift by 15-DEX from a one-bit-wider base so DEX=15 is a left shift
    always_comb begin
        dex = s2_dql_q[10:7];
        mag = 15'({1'b1, s2_dql_q[6:0], 8'b0} >> (4'd15 - dex));
        if (s2_dql_q[11]) begin
            mag = 15'd0;
        end
    end

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_dqs_d  = s1_dqs_q;
        s1_dqln_d = s1_dqln_q;
        s1_y_d    = s1_y_q;
        s2_v_d    = s2_v_q;
        s2_dqs_d  = s2_dqs_q;
        s2_dql_d  = s2_dql_q;
        out_v_d   = out_v_q;
        dq_d      = dq_q;
        if (en) begin
            s1_v_d    = IN_VALID;
            s1_dqs_d  = sgn;
            s1_dqln_d = dqln;
            s1_y_d    = Y[12:2];
            s2_v_d    = s1_v_q;
            s2_dqs_d  = s1_dqs_q;
            s2_dql_d  = s1_dqln_q + {1'b0, s1_y_q};
            out_v_d   = s2_v_q;
            dq_d      = {s2_dqs_q, mag};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_v_q    <= 1'b0;
            s1_dqs_q  <= 1'b0;
            s1_dqln_q <= 12'd0;
            s1_y_q    <= 11'd0;
            s2_v_q    <= 1'b0;
            s2_dqs_q  <= 1'b0;
            s2_dql_q  <= 12'd0;
            out_v_q   <= 1'b0;
            dq_q      <= 16'd0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_dqs_q  <= s1_dqs_d;
            s1_dqln_q <= s1_dqln_d;
            s1_y_q    <= s1_y_d;
            s2_v_q    <= s2_v_d;
            s2_dqs_q  <= s2_dqs_d;
            s2_dql_q  <= s2_dql_d;
            out_v_q   <= out_v_d;
            dq_q      <= dq_d;
        end
    end

endmodule

// File: tb/tb_adap_quan_inv.sv
// Bench for adap_quan_inv: directed G.726 vectors plus random traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_adap_quan_inv;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [4:0]  I = '0;
    logic [12:0] Y = '0;
    logic [1:0]  RATE = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [15:0] DQ;

    adap_quan_inv dut (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .I(I), .Y(Y), .RATE(RATE),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .DQ(DQ)
    );

    always #5 CLK = ~CLK;

    int n_err = 0;
    int n_chk = 0;
    int cycnt = 0;
    bit lat_on = 0;
    bit hold_on = 0;
    logic [15:0] hold_dq;
    logic [15:0] exp_q[$];
    int acc_q[$];

    int t16[2]  = '{116, 365};
    int t24[4]  = '{-2048, 135, 273, 373};
    int t32[8]  = '{-2048, 4, 135, 213, 273, 323, 373, 425};
    int t40[16] = '{-2048, -66, 28, 104, 169, 224, 274, 318,
                    358, 395, 429, 459, 488, 514, 539, 566};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_dq(input logic [4:0] ii,
                                           input logic [12:0] yy,
                                           input logic [1:0] rr);
        int n, code, neg, ix, ln, dql, dex, dqt, m;
        n    = int'(rr) + 2;
        code = int'(ii) % (1 << n);
        neg  = code / (1 << (n - 1));
        ix   = neg ? ((1 << n) - 1 - code) : code;
        case (rr)
            2'd0: ln = t16[ix];
            2'd1: ln = t24[ix];
            2'd2: ln = t32[ix];
            default: ln = t40[ix];
        endcase
        dql = (ln + 4096 + int'(yy) / 4) % 4096;
        if (dql >= 2048) m = 0;
        else begin
            dex = dql / 128;
            dqt = 128 + dql % 128;
            m   = ((dqt * 128 * (1 << dex)) / 16384) % 32768;
        end
        return {neg[0], m[14:0]};
    endfunction

    // One clock cycle: drive, observe at negedge, book-keep, advance.
    task automatic cyc(input bit iv, input logic [4:0] ii,
                       input logic [12:0] yy, input logic [1:0] rr,
                       input bit ordy, input int xp, output bit acc);
        IN_VALID = iv; I = ii; Y = yy; RATE = rr; OUT_READY = ordy;
        @(negedge CLK);
        if (hold_on) check("hold", {15'd0, OUT_VALID, DQ}, {15'd0, 1'b1, hold_dq});
        hold_on = OUT_VALID && !OUT_READY;
        hold_dq = DQ;
        check("rdy", {31'd0, IN_READY}, {31'd0, !OUT_VALID || OUT_READY});
        if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) check("spurious", 1, 0);
            else begin
                int a;
                check("dq", {16'd0, DQ}, {16'd0, exp_q.pop_front()});
                a = acc_q.pop_front();
                if (lat_on) check("lat", cycnt - a, 3);
            end
        end
        acc = IN_VALID && IN_READY;
        if (acc) begin
            exp_q.push_back(xp < 0 ? ref_dq(ii, yy, rr) : xp[15:0]);
            acc_q.push_back(cycnt);
        end
        @(posedge CLK);
        #1;
        cycnt++;
    endtask

    task automatic drain();
        bit a;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++)
            cyc(0, 0, 0, 0, 1, -1, a);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        bit a;
        int sent;
        logic [4:0] ci[8];
        logic [12:0] cy[8];
        logic [1:0] cr[8];

        #12;
        check("rst_ov", {31'd0, OUT_VALID}, 0);
        check("rst_dq", {16'd0, DQ}, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        #1;
        check("rst_rdy", {31'd0, IN_READY}, 1);

        lat_on = 1;
        cyc(1, 5'b00111, 13'd544, 2'b10, 1, 16'h0016, a);
        cyc(1, 5'b01000, 13'd544, 2'b10, 1, 16'h8016, a);
        cyc(1, 5'b00000, 13'd544, 2'b10, 1, 16'h0000, a);
        cyc(1, 5'b01111, 13'd544, 2'b10, 1, 16'h8000, a);
        cyc(1, 5'b00111, 13'h1FFF, 2'b10, 1, 16'h0000, a);
        drain();

        // rate alternates per codeword, with bits above the width set
        cyc(1, 5'b10110, 13'd1200, 2'b11, 1, -1, a);
        cyc(1, 5'b11101, 13'd1200, 2'b00, 1, -1, a);
        cyc(1, 5'b11010, 13'd1200, 2'b01, 1, -1, a);
        cyc(1, 5'b10011, 13'd1200, 2'b10, 1, -1, a);
        cyc(1, 5'b11110, 13'd3000, 2'b00, 1, -1, a);
        drain();
        lat_on = 0;

        // 8 back-to-back codewords with a 4-cycle output stall
        for (int k = 0; k < 8; k++) begin
            ci[k] = 5'($urandom);
            cy[k] = 13'($urandom);
            cr[k] = 2'($urandom);
        end
        sent = 0;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            cyc(1, ci[sent], cy[sent], cr[sent], !(c >= 4 && c < 8), -1, a);
            if (a) sent++;
        end
        check("stall_sent", sent, 8);
        drain();

        // reset with three codewords in flight
        cyc(1, 5'b00111, 13'd544, 2'b10, 1, -1, a);
        cyc(1, 5'b00101, 13'd900, 2'b10, 1, -1, a);
        cyc(1, 5'b00011, 13'd700, 2'b10, 1, -1, a);
        check("pre_rst_ov", {31'd0, OUT_VALID}, 1);
        #2;
        RESET = 1'b1;
        #1;
        check("arst_ov", {31'd0, OUT_VALID}, 0);
        check("arst_dq", {16'd0, DQ}, 0);
        exp_q.delete();
        acc_q.delete();
        hold_on = 0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1, -1, a);
        check("post_rst_ov", {31'd0, OUT_VALID}, 0);

        // random traffic
        for (int k = 0; k < 500; k++)
            cyc($urandom_range(0, 3) != 0, 5'($urandom), 13'($urandom),
                2'($urandom), $urandom_range(0, 3) != 0, -1, a);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
